uart_rx: RTL and testbench

Asynchronous serial receiver: the receive-side counterpart of the team's UART transmitter, decoding the same frame. The frame is one start bit (0), WIDTH data bits LSB first, an optional parity bit, and one stop bit (1). The block oversamples the line, validates start, parity and stop, and presents each good frame as a parallel word with a one-cycle valid pulse. It sits between the board RX pin and the register/FIFO side of the UART.

---
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling asynchronous serial receiver.
//
// Frame: start bit (0), WIDTH data bits LSB first, optional parity bit,
// one stop bit (1). Each good frame is presented on P_DATA with a one-cycle
// data_valid pulse; bad frames raise a one-cycle par_err or stp_err pulse and
// leave P_DATA untouched.
//
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN
//   defined   : each bit is the 2-of-3 vote of samples at edge_cnt
//               OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1 (decision at +1)
//   undefined : single sample at edge_cnt == OVERSAMPLE/2
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   RX_IN      serial line (idles high, asynchronous to clk)
//   PAR_EN     1 = frame carries a parity bit (captured at frame start)
//   PAR_TYP    0 = even, 1 = odd parity (captured at frame start)
//   P_DATA     last accepted data word
//   data_valid one-cycle pulse, P_DATA updated
//   par_err    one-cycle pulse, parity mismatch, frame dropped
//   stp_err    one-cycle pulse, stop bit low, frame dropped
//   state_dbg  current FSM state (IDLE=0 START=1 DATA=2 PARITY=3 STOP=4)
//
// Handshake: outputs are pulses only; there is no ready/back-pressure. A
// consumer must capture P_DATA in the cycle data_valid is high.
module uart_rx #(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RX_IN,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic [WIDTH-1:0] P_DATA,
  output logic             data_valid,
  output logic             par_err,
  output logic             stp_err,
  output logic [2:0]       state_dbg
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] MID_CNT  = CW'(OVERSAMPLE / 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             sync1, rx_s, rx_d;
  logic [CW-1:0]    edge_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             par_en_q, par_typ_q, par_bad;
  logic             fall, wrap, samp_pt, bit_val;
  logic             done_ok, done_par, done_stp;

  assign fall      = rx_d & ~rx_s;
  assign wrap      = (edge_cnt == LAST_CNT);
  assign state_dbg = state;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic vote_a, vote_b;
  // Third sample is the live rx_s at the decision edge.
  assign samp_pt = (edge_cnt == MID_CNT + CW'(1));
  assign bit_val = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else begin
      if (edge_cnt == MID_CNT - CW'(1)) vote_a <= rx_s;
      if (edge_cnt == MID_CNT)          vote_b <= rx_s;
    end
  end
`else
  assign samp_pt = (edge_cnt == MID_CNT);
  assign bit_val = rx_s;
`endif

  // Next-state and frame-result decode.
  always_comb begin
    state_nxt = state;
    done_ok   = 1'b0;
    done_par  = 1'b0;
    done_stp  = 1'b0;
    case (state)
      IDLE:   if (fall) state_nxt = START;
      START: begin
        if (samp_pt && bit_val) state_nxt = IDLE;  // glitch, not a start bit
        else if (wrap)          state_nxt = DATA;
      end
      DATA:   if (wrap && bit_cnt == LAST_BIT) state_nxt = par_en_q ? PARITY : STOP;
      PARITY: if (wrap) state_nxt = STOP;
      STOP: begin
        // Finish at the sample point so a following start edge anywhere in
        // the back half of the stop bit is seen from IDLE.
        if (samp_pt) begin
          state_nxt = IDLE;
          if (!bit_val)     done_stp = 1'b1;
          else if (par_bad) done_par = 1'b1;
          else              done_ok  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1      <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad    <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      sync1 <= RX_IN;
      rx_s  <= sync1;
      rx_d  <= rx_s;

      edge_cnt <= (state == IDLE || wrap) ? '0 : edge_cnt + CW'(1);

      if (state == IDLE) begin
        bit_cnt <= '0;
        if (fall) begin
          par_en_q  <= PAR_EN;
          par_typ_q <= PAR_TYP;
          par_bad   <= 1'b0;
        end
      end

      if (state == DATA) begin
        if (samp_pt) shreg <= {bit_val, shreg[WIDTH-1:1]};
        if (wrap)    bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
      end

      if (state == PARITY && samp_pt)
        par_bad <= (bit_val != ((^shreg) ^ par_typ_q));

      data_valid <= done_ok;
      par_err    <= done_par;
      stp_err    <= done_stp;
      if (done_ok) P_DATA <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (WIDTH=8, OVERSAMPLE=8).
// Expected result pulses (kind, P_DATA, cycle) are queued before each frame is
// driven; a negedge monitor pops and compares them as pulses appear.
module tb_uart_rx;

  localparam int W  = 8;
  localparam int OS = 8;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int           VOTE       = 1;
  localparam logic [W-1:0] GLITCH_EXP = 8'hFF;
`else
  localparam int           VOTE       = 0;
  localparam logic [W-1:0] GLITCH_EXP = 8'hFB;
`endif
  localparam int LAT_NP = 79 + VOTE;   // no parity
  localparam int LAT_P  = 87 + VOTE;   // with parity

  localparam logic [2:0] K_OK  = 3'b100;
  localparam logic [2:0] K_PAR = 3'b010;
  localparam logic [2:0] K_STP = 3'b001;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         RX_IN = 1'b1;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic [W-1:0] P_DATA;
  logic         data_valid, par_err, stp_err;
  logic [2:0]   state_dbg;

  uart_rx #(.WIDTH(W), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err),
    .stp_err(stp_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  // entry: {13'b0, kind[2:0], data[15:0], cycle[31:0]}
  logic [63:0] exp_q[$];
  logic [63:0] e;

  // Called at an aligned point (#1 after posedge, cyc = n); E0 is edge n+1.
  task automatic expect_evt(input logic [2:0] k, input logic [15:0] d, input int lat);
    exp_q.push_back({13'd0, k, d, 32'(cyc + 1 + lat)});
  endtask

  task automatic drain(input string tag);
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (data_valid | par_err | stp_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, data_valid, par_err, stp_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {29'd0, data_valid, par_err, stp_err}, {29'd0, e[50:48]});
        check("pulse_data", {24'd0, P_DATA}, {16'd0, e[47:32]});
        check("pulse_cycle", cyc, e[31:0]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // gb: data bit index that gets a one-cycle low glitch at its centre (-1 none)
  task automatic send_frame(input logic [W-1:0] d, input bit wp, input bit pb,
                            input bit sb, input int gb);
    RX_IN = 1'b0;
    step(OS);
    for (int i = 0; i < W; i++) begin
      RX_IN = d[i];
      if (i == gb) begin
        step(5);
        RX_IN = 1'b0;
        step(1);
        RX_IN = d[i];
        step(2);
      end else begin
        step(OS);
      end
    end
    if (wp) begin
      RX_IN = pb;
      step(OS);
    end
    RX_IN = sb;
    step(OS);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] pd;
    pd = 8'h5A;

    step(3);
    check("reset_p_data", {24'd0, P_DATA}, 32'd0);
    check("reset_flags", {29'd0, data_valid, par_err, stp_err}, 32'd0);
    check("reset_state", {29'd0, state_dbg}, 32'd0);
    rst = 1'b1;
    step(4);

    // plain 8N1 frame
    expect_evt(K_OK, 16'h00A5, LAT_NP);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
    step(10);
    drain("missing_a5");

    // even parity: wrong parity bit first, then correct
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b0;
    expect_evt(K_PAR, 16'h00A5, LAT_P);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1);
    step(10);
    drain("missing_par_err");
    expect_evt(K_OK, 16'h003C, LAT_P);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1);
    step(10);
    drain("missing_3c");

    // odd parity, controls changed mid-frame must be ignored
    PAR_TYP = 1'b1;
    expect_evt(K_OK, 16'h0007, LAT_P);
    fork
      send_frame(8'h07, 1'b1, 1'b0, 1'b1, -1);
      begin
        step(30);
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
      end
    join
    step(10);
    drain("missing_07_odd");

    // stop bit low, then break for 40 bit times: exactly one stp_err
    expect_evt(K_STP, 16'h0007, LAT_NP);
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, -1);
    step(40 * OS);
    drain("missing_stp_err");
    RX_IN = 1'b1;
    step(16);
    expect_evt(K_OK, 16'h0055, LAT_NP);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1);
    step(10);
    drain("missing_55");

    // 3-cycle glitch on idle line
    RX_IN = 1'b0;
    step(3);
    RX_IN = 1'b1;
    step(20);
    check("glitch_state_idle", {29'd0, state_dbg}, 32'd0);
    drain("glitch_no_pulse");

    // 1-cycle glitch at the centre of data bit 2 of 0xFF
    expect_evt(K_OK, {8'd0, GLITCH_EXP}, LAT_NP);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 2);
    step(10);
    drain("missing_glitch_frame");

    // reset during data bit 4
    RX_IN = 1'b0;
    step(OS);
    for (int i = 0; i < 4; i++) begin
      RX_IN = pd[i];
      step(OS);
    end
    RX_IN = pd[4];
    step(3);
    rst = 1'b0;
    #1;
    check("midreset_p_data", {24'd0, P_DATA}, 32'd0);
    check("midreset_flags", {29'd0, data_valid, par_err, stp_err}, 32'd0);
    check("midreset_state", {29'd0, state_dbg}, 32'd0);
    step(2);
    RX_IN = 1'b1;
    rst   = 1'b1;
    step(20);
    drain("midreset_no_pulse");
    expect_evt(K_OK, 16'h0081, LAT_NP);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, -1);
    step(10);
    drain("missing_81");

    // back-to-back frames, second start 4 cycles after the stop sample point
    expect_evt(K_OK, 16'h0012, LAT_NP);
    expect_evt(K_OK, 16'h0034, LAT_NP + 10 * OS);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1, -1);
    step(10);
    drain("missing_back_to_back");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
